// File: rtl/execute_stage_md.sv
// Registered MIPS execute stage: ALU with valid/stall/flush handshake plus an
// iterative unsigned multiply/divide unit with HI/LO registers.
module execute_stage_md #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [5:0]        i_funct,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic              i_ALUSrc,
  input  logic [1:0]        i_ALUop,
  input  logic              i_extOp,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_ALUres,
  output logic [DATA_W-1:0] o_op2,
  output logic              o_zero,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;    // product high half / partial remainder
  logic [DATA_W-1:0] work_q;   // multiplier being consumed / dividend->quotient
  logic [DATA_W-1:0] opnd_q;   // multiplicand / divisor
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              valid_q, zero_q;
  logic [DATA_W-1:0] res_q, op2_q;

  logic              accept;
  logic              is_mul, is_div;
  logic [DATA_W-1:0] ext, alu_b, res_d;
  logic [DATA_W-1:0] acc_d, work_d;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic              div_ge;

  assign o_busy   = (state_q != ST_IDLE);
  assign o_ready  = !o_busy && !i_stall;
  assign accept   = i_valid && o_ready;
  assign o_valid  = valid_q;
  assign o_ALUres = res_q;
  assign o_op2    = op2_q;
  assign o_zero   = zero_q;

  assign is_mul = (i_ALUop == 2'b10) && (i_funct == F_MULTU);
  assign is_div = (i_ALUop == 2'b10) && (i_funct == F_DIVU);

  assign ext   = i_extOp ? DATA_W'($signed(i_imm)) : DATA_W'(i_imm);
  assign alu_b = i_ALUSrc ? ext : i_op2;

  always_comb begin
    res_d = '0;
    case (i_ALUop)
      2'b00: res_d = i_op1 + alu_b;
      2'b01: res_d = i_op1 - alu_b;
      2'b11: res_d = i_op1 | alu_b;
      default: begin
        case (i_funct)
          F_ADD:  res_d = i_op1 + alu_b;
          F_SUB:  res_d = i_op1 - alu_b;
          F_AND:  res_d = i_op1 & alu_b;
          F_OR:   res_d = i_op1 | alu_b;
          F_SLT:  res_d = ($signed(i_op1) < $signed(alu_b)) ? DATA_W'(1) : '0;
          F_MFHI: res_d = hi_q;
          F_MFLO: res_d = lo_q;
          default: res_d = '0;
        endcase
      end
    endcase
  end

  // One iteration step; a zero divisor naturally yields all-ones quotient and
  // remainder equal to the dividend, so no special case is needed.
  assign mul_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
  assign div_shift = {acc_q, work_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = div_shift >= {1'b0, opnd_q};

  always_comb begin
    acc_d  = acc_q;
    work_d = work_q;
    if (state_q == ST_MUL) begin
      if (work_q[0]) {acc_d, work_d} = {mul_sum, work_q[DATA_W-1:1]};
      else           {acc_d, work_d} = {1'b0, acc_q, work_q[DATA_W-1:1]};
    end else if (state_q == ST_DIV) begin
      acc_d  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      work_d = {work_q[DATA_W-2:0], div_ge};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      op2_q   <= '0;
      zero_q  <= 1'b0;
    end else if (i_flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (is_mul || is_div)) begin
            state_q <= is_mul ? ST_MUL : ST_DIV;
            cnt_q   <= '0;
            acc_q   <= '0;
            work_q  <= i_op1;
            opnd_q  <= i_op2;
          end
        end
        default: begin
          acc_q  <= acc_d;
          work_q <= work_d;
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= acc_d;
            lo_q    <= work_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase

      if (i_stall) begin
        valid_q <= valid_q;
      end else if (accept && !is_mul && !is_div) begin
        valid_q <= 1'b1;
        res_q   <= res_d;
        op2_q   <= i_op2;
        zero_q  <= (res_d == '0);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed self-checking bench for execute_stage_md (DATA_W=32, IMM_W=16).
module tb_execute_stage_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, stall, flush, alusrc, extop;
  logic [15:0] imm;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic [1:0]  aluop;
  logic        o_ready, o_valid, o_zero, o_busy;
  logic [31:0] o_res, o_op2;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_hi;
  int cyc;

  execute_stage_md #(.DATA_W(32), .IMM_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_stall(stall), .i_flush(flush), .i_imm(imm), .i_funct(funct),
    .i_op1(op1), .i_op2(op2), .i_ALUSrc(alusrc), .i_ALUop(aluop),
    .i_extOp(extop), .o_valid(o_valid), .o_ALUres(o_res), .o_op2(o_op2),
    .o_zero(o_zero), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic drv(input logic [1:0] op, input logic [5:0] fn, input logic src,
                     input logic ex, input logic [31:0] a, input logic [31:0] b,
                     input logic [15:0] im);
    aluop = op; funct = fn; alusrc = src; extop = ex;
    op1 = a; op2 = b; imm = im; valid = 1'b1;
  endtask

  // Issue one instruction, let it take one edge, return to idle.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic ex, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im);
    drv(op, fn, src, ex, a, b, im);
    @(negedge clk);
    idle();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    rdy_hi = 0;
    while (o_busy && n < 100) begin
      if (o_ready) rdy_hi++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    drv(2'b00, 6'h0, 1'b0, 1'b0, '0, '0, '0);
    valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_res",   o_res,   0);
    chk("rst_busy",  o_busy,  0);
    chk("rst_ready", o_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b10, 6'h20, 1'b0, 1'b0, 32'd5, 32'd7, 16'h0);
    chk("add_valid", o_valid, 1);
    chk("add_res",   o_res,   12);
    chk("add_zero",  o_zero,  0);
    chk("add_op2",   o_op2,   7);
    @(negedge clk);
    chk("idle_valid", o_valid, 0);

    issue(2'b00, 6'h0, 1'b1, 1'b1, 32'h100, 32'h0, 16'hFFFC);
    chk("addi_sext", o_res, 32'hFC);
    issue(2'b00, 6'h0, 1'b1, 1'b0, 32'h100, 32'h0, 16'hFFFC);
    chk("addi_zext", o_res, 32'h100FC);
    issue(2'b01, 6'h0, 1'b0, 1'b0, 32'h55, 32'h55, 16'h0);
    chk("sub_res",  o_res,  0);
    chk("sub_zero", o_zero, 1);
    issue(2'b10, 6'h2A, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 16'h0);
    chk("slt_neg", o_res, 1);
    issue(2'b10, 6'h24, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 16'h0);
    chk("and_res", o_res, 32'h00F0);
    issue(2'b11, 6'h0, 1'b1, 1'b0, 32'hF000, 32'h0, 16'h000F);
    chk("ori_res", o_res, 32'hF00F);
    issue(2'b10, 6'h3F, 1'b0, 1'b0, 32'd5, 32'd7, 16'h0);
    chk("bad_funct", o_res, 0);

    issue(2'b10, 6'h19, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 16'h0);
    chk("mul_valid", o_valid, 0);
    wait_idle(cyc);
    chk("mul_cycles", cyc, 32);
    chk("mul_ready_low", rdy_hi, 0);
    issue(2'b10, 6'h10, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("mul_hi", o_res, 1);
    issue(2'b10, 6'h12, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("mul_lo", o_res, 32'hFFFFFFFE);

    issue(2'b10, 6'h1B, 1'b0, 1'b0, 32'd100, 32'd7, 16'h0);
    wait_idle(cyc);
    chk("div_cycles", cyc, 32);
    issue(2'b10, 6'h10, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("div_hi", o_res, 2);
    issue(2'b10, 6'h12, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("div_lo", o_res, 14);

    issue(2'b10, 6'h1B, 1'b0, 1'b0, 32'd9, 32'd0, 16'h0);
    wait_idle(cyc);
    chk("div0_cycles", cyc, 32);
    issue(2'b10, 6'h12, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("div0_lo", o_res, 32'hFFFFFFFF);
    issue(2'b10, 6'h10, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("div0_hi", o_res, 9);

    issue(2'b01, 6'h0, 1'b0, 1'b0, 32'd20, 32'd5, 16'h0);
    chk("stl_pre", o_res, 15);
    drv(2'b10, 6'h20, 1'b0, 1'b0, 32'd1, 32'd1, 16'h0);
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stl_res",   o_res,   15);
      chk("stl_valid", o_valid, 1);
      chk("stl_ready", o_ready, 0);
    end
    stall = 1'b0;
    @(negedge clk);
    idle();
    chk("stl_next_res", o_res, 2);
    chk("stl_next_vld", o_valid, 1);

    issue(2'b10, 6'h19, 1'b0, 1'b0, 32'h1234, 32'h10, 16'h0);
    repeat (9) @(negedge clk);
    chk("fl_busy_pre", o_busy, 1);
    drv(2'b10, 6'h20, 1'b0, 1'b0, 32'd3, 32'd4, 16'h0);
    flush = 1'b1;
    @(negedge clk);
    idle();
    chk("fl_busy",  o_busy,  0);
    chk("fl_valid", o_valid, 0);
    chk("fl_ready", o_ready, 1);
    issue(2'b10, 6'h12, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("fl_lo", o_res, 32'hFFFFFFFF);
    issue(2'b10, 6'h10, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("fl_hi", o_res, 9);

    issue(2'b10, 6'h1B, 1'b0, 1'b0, 32'd100, 32'd7, 16'h0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_res",   o_res,   0);
    chk("ar_op2",   o_op2,   0);
    chk("ar_zero",  o_zero,  0);
    chk("ar_busy",  o_busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b10, 6'h12, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk("ar_lo", o_res, 0);
    chk("ar_lo_zero", o_zero, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Registered execute stage for the pipelined MIPS core. Sits between the decode/ID-EX and EX-MEM boundaries.
- Generalises the combinational execute block:
  - data and immediate widths are parametrised;
  - the output is registered, with a valid/ready/stall/flush handshake;
  - adds an iterative unsigned multiply/divide unit with internal HI/LO registers, readable via mfhi/mflo.

Parameters:
DATA_W, 32, operand/result width (even, >=8)
IMM_W, 16, immediate field width (IMM_W <= DATA_W)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream presents an instruction
o_ready  output  1  stage accepts instruction this cycle
i_stall  input  1  downstream cannot take output this cycle
i_flush  input  1  kill output and any in-progress mult/div
i_imm  input  IMM_W  immediate field
i_funct  input  6  R-type function field
i_op1  input  DATA_W  rs operand
i_op2  input  DATA_W  rt operand
i_ALUSrc  input  1  0: op2 is ALU B input; 1: extended immediate
i_ALUop  input  2  00 add, 01 sub, 10 R-type (funct), 11 or
i_extOp  input  1  1: sign-extend immediate; 0: zero-extend
o_valid  output  1  output registers hold a valid result
o_ALUres  output  DATA_W  registered result
o_op2  output  DATA_W  registered i_op2 (store data)
o_zero  output  1  registered (result == 0)
o_busy  output  1  mult/div iteration in progress

Behaviour:
- Reset (i_rst_n low, async): o_valid=0, o_ALUres=0, o_op2=0, o_zero=0, o_busy=0. HI=0, LO=0. Iteration counter=0.
- o_ready = !o_busy && !i_stall (combinational).
- Accept condition: i_valid && o_ready.
- Immediate extension: sign- or zero-extend i_imm to DATA_W per i_extOp. B = i_ALUSrc ? ext : i_op2.
- R-type funct decode:
  - 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x2A slt (signed, result 1/0);
  - 0x10 mfhi; 0x12 mflo;
  - 0x19 multu; 0x1B divu;
  - any other funct: result 0.
- Arithmetic: add/sub wrap modulo 2^DATA_W. No overflow trap.
- ALU ops (latency 1): on accept, the next edge loads o_ALUres, o_op2 and o_zero, and sets o_valid=1.
- Stall: while i_stall=1, all output registers hold.
- No accept and no stall: o_valid clears to 0 at the next edge.
- multu/divu on accept:
  - operands are latched; o_busy=1 from the next edge; o_valid=0 at the next edge (no GPR result).
  - exactly DATA_W iteration cycles:
    - multu: shift-add;
    - divu: restoring, one quotient bit per cycle.
  - On the final iteration edge: HI/LO are written and o_busy drops.
    - multu: {HI,LO} = op1*op2 (2*DATA_W-bit product).
    - divu: LO = quotient, HI = remainder.
  - If accepted at edge N, HI/LO are updated and o_busy=0 after edge N+DATA_W. mfhi/mflo can be accepted in the cycle after that edge.
  - Division by zero: LO = all ones, HI = op1. Same DATA_W-cycle latency.
- mfhi/mflo: while o_busy=1 they cannot be accepted (o_ready=0), so they always read final values.
- i_stall has no effect on a mult/div iteration; the iteration continues.
- i_flush (highest priority after reset), at the next edge:
  - o_valid=0;
  - an in-progress mult/div is aborted: o_busy=0, HI/LO unchanged, counter cleared;
  - any instruction presented in the same cycle is discarded.
- Reset asserted mid-iteration: immediate return to reset state.
- Simultaneous i_flush and i_stall: flush wins; o_valid=0.

Test Plan:
- Reset, then ALUop=10, funct=0x20, op1=5, op2=7, ALUSrc=0 -> one cycle later o_valid=1, o_ALUres=12, o_zero=0.
- ALUop=00, ALUSrc=1, imm=0xFFFC, extOp=1, op1=0x100 -> o_ALUres=0xFC. Same with extOp=0 -> 0x100FC.
- multu op1=0xFFFFFFFF, op2=2 -> o_busy high exactly 32 cycles, o_ready low throughout. Following mfhi -> 1; mflo -> 0xFFFFFFFE.
- divu op1=100, op2=7 -> HI=2, LO=14. divu op1=9, op2=0 -> LO=0xFFFFFFFF, HI=9.
- Valid sub result with i_stall held 3 cycles -> outputs unchanged, o_ready=0. Release -> next instruction accepted.
- i_flush asserted 10 cycles into a multu -> o_busy=0 next cycle, a following mflo returns the prior LO value. Async reset mid-divu -> all outputs 0 immediately.
